// File: rtl/dds_pkg.sv
// Shared DDS widths and phase/frequency word types, common to the phase generator and the LUT stage.
package dds_pkg;

    localparam int DDS_PHASE_WIDTH     = 32;
    localparam int DDS_LUT_PHASE_WIDTH = 18;

    typedef logic [DDS_PHASE_WIDTH-1:0]     freq_t;
    typedef logic [DDS_LUT_PHASE_WIDTH-1:0] phase_t;

endpackage

// File: rtl/dds_phase_gen.sv
// Phase accumulator emitting one AXI-stream phase word per accepted sample for the DDS LUT stage.
// Define DDS_PHASE_GEN_SWEEP_EN to add a linear-chirp sweep input that steps the frequency every load.
module dds_phase_gen
    import dds_pkg::*;
#(
    parameter int               WIDTH         = DDS_PHASE_WIDTH,
    parameter int               OUTPUT_WIDTH  = DDS_LUT_PHASE_WIDTH,
    parameter logic [WIDTH-1:0] INITIAL_PHASE = '0,
    parameter logic [WIDTH-1:0] INITIAL_FREQ  = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        input_freq_tdata,
    input  logic                    input_freq_tvalid,
    output logic                    input_freq_tready,
    input  logic [WIDTH-1:0]        input_offset_tdata,
    input  logic                    input_offset_tvalid,
    output logic                    input_offset_tready,
`ifdef DDS_PHASE_GEN_SWEEP_EN
    input  logic [WIDTH-1:0]        input_sweep_tdata,
    input  logic                    input_sweep_tvalid,
    output logic                    input_sweep_tready,
`endif
    input  logic                    sync,
    output logic [OUTPUT_WIDTH-1:0] output_phase_tdata,
    output logic                    output_phase_tvalid,
    input  logic                    output_phase_tready
);

    logic [WIDTH-1:0]        acc_q, acc_d;
    logic [WIDTH-1:0]        freq_q, freq_d;
    logic [WIDTH-1:0]        offset_q, offset_d;
    logic [OUTPUT_WIDTH-1:0] out_q, out_d;
    logic                    valid_q, valid_d;
    logic                    load;

    // Keep the top OUTPUT_WIDTH bits of the wrapped phase sum; plain truncation, no rounding.
    function automatic logic [OUTPUT_WIDTH-1:0] phase_trunc(input logic [WIDTH-1:0] sum);
        return OUTPUT_WIDTH'(sum >> (WIDTH - OUTPUT_WIDTH));
    endfunction

    assign input_freq_tready   = !rst;
    assign input_offset_tready = !rst;

`ifdef DDS_PHASE_GEN_SWEEP_EN
    logic [WIDTH-1:0] sweep_q, sweep_d;

    assign input_sweep_tready = !rst;
`endif

    always_comb begin
        load     = !valid_q || output_phase_tready;
        acc_d    = acc_q;
        freq_d   = freq_q;
        offset_d = offset_q;
        out_d    = out_q;
        valid_d  = valid_q;
`ifdef DDS_PHASE_GEN_SWEEP_EN
        sweep_d  = sweep_q;
`endif

        if (load) begin
            out_d   = phase_trunc(acc_q + offset_q);
            acc_d   = acc_q + freq_q;
            valid_d = 1'b1;
`ifdef DDS_PHASE_GEN_SWEEP_EN
            freq_d  = freq_q + sweep_q;
`endif
        end

        // Register writes land after this edge's load, so the load above always sees the old values.
        if (sync) begin
            acc_d = INITIAL_PHASE;
        end
        if (input_freq_tvalid) begin
            freq_d = input_freq_tdata;
        end
        if (input_offset_tvalid) begin
            offset_d = input_offset_tdata;
        end
`ifdef DDS_PHASE_GEN_SWEEP_EN
        if (input_sweep_tvalid) begin
            sweep_d = input_sweep_tdata;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= INITIAL_PHASE;
            freq_q   <= INITIAL_FREQ;
            offset_q <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
`ifdef DDS_PHASE_GEN_SWEEP_EN
            sweep_q  <= '0;
`endif
        end else begin
            acc_q    <= acc_d;
            freq_q   <= freq_d;
            offset_q <= offset_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
`ifdef DDS_PHASE_GEN_SWEEP_EN
            sweep_q  <= sweep_d;
`endif
        end
    end

    assign output_phase_tdata  = out_q;
    assign output_phase_tvalid = valid_q;

endmodule

// File: tb/tb_dds_phase_gen.sv
// Directed bench for dds_phase_gen with INITIAL_FREQ = 0x40000000 (quarter-turn per sample).
module tb_dds_phase_gen;

    localparam int WIDTH        = 32;
    localparam int OUTPUT_WIDTH = 18;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [WIDTH-1:0]        input_freq_tdata = '0;
    logic                    input_freq_tvalid = 1'b0;
    logic                    input_freq_tready;
    logic [WIDTH-1:0]        input_offset_tdata = '0;
    logic                    input_offset_tvalid = 1'b0;
    logic                    input_offset_tready;
`ifdef DDS_PHASE_GEN_SWEEP_EN
    logic [WIDTH-1:0]        input_sweep_tdata = '0;
    logic                    input_sweep_tvalid = 1'b0;
    logic                    input_sweep_tready;
`endif
    logic                    sync = 1'b0;
    logic [OUTPUT_WIDTH-1:0] output_phase_tdata;
    logic                    output_phase_tvalid;
    logic                    output_phase_tready = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    dds_phase_gen #(
        .WIDTH        (WIDTH),
        .OUTPUT_WIDTH (OUTPUT_WIDTH),
        .INITIAL_PHASE(32'h0000_0000),
        .INITIAL_FREQ (32'h4000_0000)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .input_freq_tdata   (input_freq_tdata),
        .input_freq_tvalid  (input_freq_tvalid),
        .input_freq_tready  (input_freq_tready),
        .input_offset_tdata (input_offset_tdata),
        .input_offset_tvalid(input_offset_tvalid),
        .input_offset_tready(input_offset_tready),
`ifdef DDS_PHASE_GEN_SWEEP_EN
        .input_sweep_tdata  (input_sweep_tdata),
        .input_sweep_tvalid (input_sweep_tvalid),
        .input_sweep_tready (input_sweep_tready),
`endif
        .sync               (sync),
        .output_phase_tdata (output_phase_tdata),
        .output_phase_tvalid(output_phase_tvalid),
        .output_phase_tready(output_phase_tready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One active edge passes; outputs are then sampled mid-cycle on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic step_chk(input string tag, input logic [OUTPUT_WIDTH-1:0] exp);
        tick();
        chk(tag, 32'(output_phase_tdata), 32'(exp));
        chk({tag, "_vld"}, 32'(output_phase_tvalid), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        chk("rst_tvalid", 32'(output_phase_tvalid), 32'd0);
        chk("rst_tdata", 32'(output_phase_tdata), 32'd0);
        chk("rst_freq_rdy", 32'(input_freq_tready), 32'd0);
        chk("rst_off_rdy", 32'(input_offset_tready), 32'd0);

        // Free-running quarter-turn ramp with wrap.
        rst = 1'b0;
        step_chk("ramp0", 18'h00000);
        chk("freq_rdy", 32'(input_freq_tready), 32'd1);
        chk("off_rdy", 32'(input_offset_tready), 32'd1);
        step_chk("ramp1", 18'h10000);
        step_chk("ramp2", 18'h20000);
        step_chk("ramp3", 18'h30000);
        step_chk("ramp_wrap", 18'h00000);

        // Backpressure holds the sample without skipping.
        step_chk("bp_pre", 18'h10000);
        output_phase_tready = 1'b0;
        for (int i = 0; i < 3; i++) step_chk("bp_hold", 18'h10000);
        output_phase_tready = 1'b1;
        step_chk("bp_next", 18'h20000);
        step_chk("bp_next2", 18'h30000);

        // Half-turn offset; the coincident load stays unshifted.
        input_offset_tdata  = 32'h8000_0000;
        input_offset_tvalid = 1'b1;
        step_chk("off_coinc", 18'h00000);
        input_offset_tvalid = 1'b0;
        step_chk("off1", 18'h30000);
        step_chk("off2", 18'h00000);
        step_chk("off3", 18'h10000);
        step_chk("off4", 18'h20000);
        input_offset_tdata  = 32'h0000_0000;
        input_offset_tvalid = 1'b1;
        step_chk("off_clr_coinc", 18'h30000);
        input_offset_tvalid = 1'b0;
        step_chk("off_clr", 18'h20000);

        // Sync while streaming: coincident load normal, then restart from phase 0.
        step_chk("pre_sync0", 18'h30000);
        step_chk("pre_sync1", 18'h00000);
        sync = 1'b1;
        step_chk("sync_coinc", 18'h10000);
        sync = 1'b0;
        step_chk("sync_next", 18'h00000);
        step_chk("sync_next2", 18'h10000);

        // Sync while stalled: held sample delivered, then restart.
        step_chk("pre_hold", 18'h20000);
        output_phase_tready = 1'b0;
        sync = 1'b1;
        step_chk("hsync_hold", 18'h20000);
        sync = 1'b0;
        step_chk("hsync_hold2", 18'h20000);
        output_phase_tready = 1'b1;
        step_chk("hsync_next", 18'h00000);
        step_chk("hsync_next2", 18'h10000);

        // Frequency write to an eighth-turn step; takes effect from the next load.
        input_freq_tdata  = 32'h2000_0000;
        input_freq_tvalid = 1'b1;
        step_chk("fw_coinc", 18'h20000);
        input_freq_tvalid = 1'b0;
        step_chk("fw1", 18'h30000);
        step_chk("fw2", 18'h38000);
        step_chk("fw3", 18'h00000);

        // Asynchronous reset mid-cycle clears outputs before the next edge.
        #2;
        rst = 1'b1;
        #1;
        chk("arst_tvalid", 32'(output_phase_tvalid), 32'd0);
        chk("arst_tdata", 32'(output_phase_tdata), 32'd0);
        chk("arst_freq_rdy", 32'(input_freq_tready), 32'd0);
        tick();
        rst = 1'b0;
        step_chk("rr0", 18'h00000);
        step_chk("rr1", 18'h10000);
        step_chk("rr2", 18'h20000);

`ifdef DDS_PHASE_GEN_SWEEP_EN
        // Chirp: freq 0, sweep 0x4000 loaded while stalled and with acc cleared by sync.
        output_phase_tready = 1'b0;
        input_freq_tdata    = 32'h0000_0000;
        input_freq_tvalid   = 1'b1;
        input_sweep_tdata   = 32'h0000_4000;
        input_sweep_tvalid  = 1'b1;
        sync                = 1'b1;
        tick();
        input_freq_tvalid   = 1'b0;
        input_sweep_tvalid  = 1'b0;
        sync                = 1'b0;
        chk("sw_rdy", 32'(input_sweep_tready), 32'd1);
        output_phase_tready = 1'b1;
        step_chk("sw0", 18'h00000);
        step_chk("sw1", 18'h00000);
        step_chk("sw2", 18'h00001);
        step_chk("sw3", 18'h00003);
        step_chk("sw4", 18'h00006);
        step_chk("sw5", 18'h0000A);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
